// File: rtl/uart_rx_frame_collector.sv
// Collects UART bytes into a FIFO, then drains them at a paced rate after a full frame or an idle timeout.
// Optional pattern checker on the drained stream: define RX_PATTERN_CHECK_EN.
module uart_rx_frame_collector #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned FRAME_LEN   = 256,
   parameter int unsigned TIMEOUT_CYC = 5000000,
   parameter int unsigned DRAIN_GAP   = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_done,
   input  logic [7:0] uart_dout,
   input  logic       clear,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic       busy,
   output logic       frame_done,
   output logic [8:0] rx_count,
   output logic       timeout,
   output logic [7:0] ovf_cnt,
   output logic [3:0] state_dbg
`ifdef RX_PATTERN_CHECK_EN
   ,
   output logic [8:0] err_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GW = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_COLLECT = 4'b0010,
      S_DRAIN   = 4'b0100,
      S_DONE    = 4'b1000
   } state_e;

   state_e         state_q, state_d;
   logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]     mem_q [DEPTH];
   logic [8:0]     rx_count_q, rx_count_d;
   logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
   logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
   logic           timeout_q, timeout_d;
   logic [7:0]     ovf_cnt_q, ovf_cnt_d;
   logic [7:0]     dout_q, dout_d;
   logic           dout_valid_q, dout_valid_d;

   logic fifo_full, fifo_empty;
   logic wr_en, rd_en, drop;
   logic rx_last, idle_expire, gap_done;

   assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
   assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rx_last     = (rx_count_q == 9'(FRAME_LEN - 1));
   assign idle_expire = (idle_cnt_q == IW'(TIMEOUT_CYC - 1));
   assign gap_done    = (gap_cnt_q == GW'(DRAIN_GAP - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (uart_done) state_d = (FRAME_LEN == 1) ? S_DRAIN : S_COLLECT;
         end
         S_COLLECT: begin
            if (wr_en && rx_last)         state_d = S_DRAIN;
            else if (!wr_en && idle_expire) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // A pop registers dout on the same edge it retires, so empty means nothing is pending
            if (fifo_empty) state_d = S_DONE;
         end
         S_DONE: begin
            if (clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      drop       = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      state_dbg  = state_q;
      unique case (state_q)
         S_IDLE: wr_en = uart_done;
         S_COLLECT: begin
            busy  = 1'b1;
            wr_en = uart_done && !fifo_full;
            drop  = uart_done && fifo_full;
         end
         S_DRAIN: begin
            busy  = 1'b1;
            rd_en = gap_done && !fifo_empty;
            drop  = uart_done;
         end
         S_DONE: begin
            frame_done = 1'b1;
            drop       = uart_done && !clear;
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q + (AW + 1)'(wr_en);
      rd_ptr_d     = rd_ptr_q + (AW + 1)'(rd_en);
      rx_count_d   = rx_count_q;
      idle_cnt_d   = idle_cnt_q;
      gap_cnt_d    = '0;
      timeout_d    = timeout_q;
      ovf_cnt_d    = ovf_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            idle_cnt_d = '0;
            if (uart_done) rx_count_d = 9'd1;
         end
         S_COLLECT: begin
            if (wr_en) begin
               rx_count_d = rx_count_q + 9'd1;
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + IW'(1);
               if (idle_expire) timeout_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (!gap_done) gap_cnt_d = gap_cnt_q + GW'(1);
         end
         S_DONE: begin
            if (clear) begin
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               rx_count_d = '0;
               timeout_d  = 1'b0;
               ovf_cnt_d  = '0;
            end
         end
         default: ;
      endcase
      if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 8'd1;
      if (rd_en) begin
         dout_d       = mem_q[rd_ptr_q[AW-1:0]];
         dout_valid_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rx_count_q   <= '0;
         idle_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         timeout_q    <= 1'b0;
         ovf_cnt_q    <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rx_count_q   <= rx_count_d;
         idle_cnt_q   <= idle_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         timeout_q    <= timeout_d;
         ovf_cnt_q    <= ovf_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= uart_dout;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign rx_count   = rx_count_q;
   assign timeout    = timeout_q;
   assign ovf_cnt    = ovf_cnt_q;

`ifdef RX_PATTERN_CHECK_EN
   logic [7:0] exp_q, exp_d;
   logic [8:0] err_cnt_q, err_cnt_d;

   // Drained stream is expected to count 0x00, 0x01, ... from reset or clear
   always_comb begin
      exp_d     = exp_q;
      err_cnt_d = err_cnt_q;
      if ((state_q == S_DONE) && clear) begin
         exp_d     = '0;
         err_cnt_d = '0;
      end else if (dout_valid_q) begin
         if ((dout_q != exp_q) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 9'd1;
         exp_d = exp_q + 8'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         exp_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         exp_q     <= exp_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_collector.sv
// Directed/random bench for uart_rx_frame_collector: queue-based reference of accepted bytes,
// drops and drain timing.
module tb_uart_rx_frame_collector;

   localparam int unsigned TO  = 1000;
   localparam int unsigned FL  = 256;
   localparam int unsigned GAP = 4;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       uart_done = 1'b0;
   logic [7:0] uart_dout = 8'h00;
   logic       clear     = 1'b0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       busy;
   logic       frame_done;
   logic [8:0] rx_count;
   logic       timeout;
   logic [7:0] ovf_cnt;
   logic [3:0] state_dbg;
`ifdef RX_PATTERN_CHECK_EN
   logic [8:0] err_cnt;
`endif

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned model_ovf;
   byte unsigned model_q[$];
   byte unsigned got_q[$];
   int unsigned  got_t[$];

   uart_rx_frame_collector #(
      .DEPTH      (256),
      .FRAME_LEN  (FL),
      .TIMEOUT_CYC(TO),
      .DRAIN_GAP  (GAP)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uart_done (uart_done),
      .uart_dout (uart_dout),
      .clear     (clear),
      .dout      (dout),
      .dout_valid(dout_valid),
      .busy      (busy),
      .frame_done(frame_done),
      .rx_count  (rx_count),
      .timeout   (timeout),
      .ovf_cnt   (ovf_cnt),
      .state_dbg (state_dbg)
`ifdef RX_PATTERN_CHECK_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (dout_valid === 1'b1) begin
         got_q.push_back(dout);
         got_t.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send(input logic [7:0] b);
      uart_dout = b;
      uart_done = 1'b1;
      @(negedge sys_clk);
      uart_done = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      for (int unsigned i = 0; i < budget && frame_done !== 1'b1; i++) @(negedge sys_clk);
      check("frame_done_reached", 32'(frame_done), 32'd1);
   endtask

   task automatic wait_timeout(input int unsigned budget);
      for (int unsigned i = 0; i < budget && timeout !== 1'b1; i++) @(negedge sys_clk);
   endtask

   task automatic check_drain(input string tag);
      int unsigned n;
      check({tag, "_count"}, got_q.size(), model_q.size());
      n = (got_q.size() < model_q.size()) ? got_q.size() : model_q.size();
      for (int unsigned i = 0; i < n; i++) begin
         check({tag, "_byte"}, 32'(got_q[i]), 32'(model_q[i]));
         if (i > 0) check({tag, "_spacing"}, got_t[i] - got_t[i-1], GAP);
      end
   endtask

   function automatic int unsigned pattern_errs();
      int unsigned e = 0;
      foreach (model_q[i]) if (model_q[i] != 8'(i)) e++;
      return e;
   endfunction

   task automatic flush_queues();
      model_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   initial begin
      int unsigned  enter_cyc;
      int unsigned  last_cyc;
      byte unsigned b;

      // reset state
      idle(2);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_dout_valid", 32'(dout_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_rx_count", 32'(rx_count), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_ovf", 32'(ovf_cnt), 32'd0);
      check("rst_state", 32'(state_dbg), 32'h1);
      sys_rst_n = 1'b1;
      idle(3);
      check("idle_no_timeout", 32'(state_dbg), 32'h1);

      // full frame 0x00..0xFF, 20 cycles apart
      for (int unsigned i = 0; i < FL; i++) begin
         send(8'(i));
         model_q.push_back(8'(i));
         if (i == 0) check("collect_entered", 32'(state_dbg), 32'h2);
         if (i < FL - 1) idle(19);
      end
      enter_cyc = cyc;
      check("frame_rx_count", 32'(rx_count), FL);
      check("frame_drain_state", 32'(state_dbg), 32'h4);
      check("frame_busy", 32'(busy), 32'd1);
      wait_done(FL * GAP + 20);
      check_drain("frame0");
      if (got_t.size() > 0) check("first_pop_latency", got_t[0] - enter_cyc, GAP);
      check("frame0_timeout", 32'(timeout), 32'd0);
      check("frame0_ovf", 32'(ovf_cnt), 32'd0);
      check("frame0_state", 32'(state_dbg), 32'h8);
      check("frame0_busy", 32'(busy), 32'd0);
`ifdef RX_PATTERN_CHECK_EN
      check("frame0_err_cnt", 32'(err_cnt), pattern_errs());
`endif
      idle(5);
      check("done_hold_valid", 32'(dout_valid), 32'd0);
      check("done_hold_dout", 32'(dout), 32'hFF);
      check("done_hold_rx", 32'(rx_count), FL);

      clear = 1'b1;
      @(negedge sys_clk);
      clear = 1'b0;
      check("clear_state", 32'(state_dbg), 32'h1);
      check("clear_rx_count", 32'(rx_count), 32'd0);
      flush_queues();

      // timeout-terminated frame of 10 random bytes, then drops in DRAIN and DONE
      model_ovf = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         b = 8'($urandom_range(0, 8'hA9));
         send(b);
         model_q.push_back(b);
         if (i < 9) idle($urandom_range(0, 29));
      end
      last_cyc = cyc;
      wait_timeout(TO + 20);
      check("timeout_set", 32'(timeout), 32'd1);
      check("timeout_latency", cyc - last_cyc, TO);
      check("timeout_drain_state", 32'(state_dbg), 32'h4);
      idle(1);
      send(8'hAA);
      model_ovf++;
      wait_done(10 * GAP + 20);
      send(8'hAA);
      model_ovf++;
      idle(1);
      send(8'hAA);
      model_ovf++;
      idle(1);
      check("drop_ovf", 32'(ovf_cnt), model_ovf);
      check("drop_rx_count", 32'(rx_count), 32'd10);
      check("drop_timeout_sticky", 32'(timeout), 32'd1);
      check("drop_frame_done", 32'(frame_done), 32'd1);
      check_drain("timeout_frame");

      // clear coincident with uart_done in DONE: clear wins, byte discarded
      uart_dout = 8'h77;
      uart_done = 1'b1;
      clear     = 1'b1;
      @(negedge sys_clk);
      uart_done = 1'b0;
      clear     = 1'b0;
      check("clr_state", 32'(state_dbg), 32'h1);
      check("clr_rx_count", 32'(rx_count), 32'd0);
      check("clr_ovf", 32'(ovf_cnt), 32'd0);
      check("clr_timeout", 32'(timeout), 32'd0);
      check("clr_frame_done", 32'(frame_done), 32'd0);
      flush_queues();
      b = 8'($urandom_range(0, 255));
      send(b);
      model_q.push_back(b);
      wait_timeout(TO + 20);
      wait_done(GAP + 20);
      check_drain("after_clear");
      check("after_clear_rx", 32'(rx_count), 32'd1);

      // asynchronous reset in the middle of collection
      clear = 1'b1;
      @(negedge sys_clk);
      clear = 1'b0;
      for (int unsigned i = 0; i < 100; i++) begin
         send(8'($urandom_range(0, 255)));
         idle($urandom_range(0, 4));
      end
      check("mid_collect_state", 32'(state_dbg), 32'h2);
      check("mid_collect_rx", 32'(rx_count), 32'd100);
      sys_rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state_dbg), 32'h1);
      check("arst_rx_count", 32'(rx_count), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_dout", 32'(dout), 32'd0);
      check("arst_ovf", 32'(ovf_cnt), 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      flush_queues();

      // frame after reset: counting pattern with one corrupted byte at index 16
      for (int unsigned i = 0; i < FL; i++) begin
         b = (i == 16) ? 8'h55 : 8'(i);
         send(b);
         model_q.push_back(b);
         if (i < FL - 1) idle($urandom_range(0, 7));
      end
      enter_cyc = cyc;
      check("post_rst_rx_count", 32'(rx_count), FL);
      wait_done(FL * GAP + 20);
      check_drain("post_rst_frame");
      if (got_t.size() > 0) check("post_rst_first_pop", got_t[0] - enter_cyc, GAP);
      check("post_rst_ovf", 32'(ovf_cnt), 32'd0);
      check("post_rst_timeout", 32'(timeout), 32'd0);
`ifdef RX_PATTERN_CHECK_EN
      check("post_rst_err_cnt", 32'(err_cnt), pattern_errs());
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_collector.md
Name: uart_rx_frame_collector

Overview:
Receive-side companion to the loopback byte generator and transmitter. Takes the one-cycle byte strobe from the UART receiver (uart_done / uart_dout) and stores each byte in an internal 8-bit synchronous FIFO. After a full frame, or after an inter-byte timeout, it drains the FIFO at a paced rate onto a registered output for logic-analyser capture. It exposes status and counters for debug.

Parameters:
DEPTH, 256, FIFO depth in bytes; power of two, at least FRAME_LEN.
FRAME_LEN, 256, number of bytes accepted before the drain starts automatically.
TIMEOUT_CYC, 5000000, idle sys_clk cycles after the last accepted byte that abort collection.
DRAIN_GAP, 4, sys_clk cycles between successive FIFO reads during drain; minimum 1.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset
uart_done  in  1  one-cycle strobe: uart_dout holds a valid received byte
uart_dout  in  8  received byte
clear  in  1  one-cycle pulse: return from DONE to IDLE and clear status
dout  out  8  drained byte, registered
dout_valid  out  1  one-cycle strobe qualifying dout
busy  out  1  high in COLLECT or DRAIN
frame_done  out  1  high (level) while in DONE
rx_count  out  9  bytes accepted in the current frame, 0..FRAME_LEN
timeout  out  1  sticky; set when collection ended by timeout
ovf_cnt  out  8  bytes dropped, saturating at 255
state_dbg  out  4  one-hot state, for ILA

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is sys_clk. All outputs and counters reset to 0, state goes to IDLE, FIFO pointers are cleared.
- FIFO: write/read pointers are $clog2(DEPTH)+1 bits wide. Full = MSBs differ and lower bits are equal; empty = pointers equal. Pointers wrap modulo 2*DEPTH.
- States (one-hot): IDLE=0001, COLLECT=0010, DRAIN=0100, DONE=1000.
- IDLE
  - uart_done: write byte, rx_count=1, go to COLLECT.
  - If FRAME_LEN==1, go directly to DRAIN.
- COLLECT
  - Each uart_done writes the byte, increments rx_count and reloads the idle counter.
  - The cycle the FRAME_LEN-th byte is written, the state becomes DRAIN on the next edge.
  - The idle counter increments on every cycle without uart_done. When it reaches TIMEOUT_CYC, set timeout=1 and go to DRAIN.
  - The timeout is armed only after the first byte, so no timeout is possible in IDLE.
- DRAIN
  - The gap counter counts DRAIN_GAP cycles. When it expires and the FIFO is not empty, pop one byte.
  - dout and dout_valid are registered the cycle after the pop (read latency 1).
  - The first pop occurs DRAIN_GAP cycles after entering DRAIN.
  - When the FIFO is empty and no read is pending, go to DONE.
- DONE
  - frame_done=1 and all outputs hold.
  - clear: go to IDLE, clear rx_count, timeout and ovf_cnt, reset FIFO pointers.
- Drops: uart_done in DRAIN or DONE, or in COLLECT with the FIFO full, drops the byte and increments ovf_cnt (saturating). A dropped byte does not update rx_count or the idle counter.
- Simultaneous events:
  - clear together with uart_done in DONE: clear wins, and the byte is dropped without being counted.
  - clear outside DONE is ignored.
- busy=1 in COLLECT and DRAIN.
- dout is never written while dout_valid=0; it holds its last value.

Optional Feature:
Macro RX_PATTERN_CHECK_EN.
- Defined:
  - Adds output err_cnt (9 bits, saturating at 511) and an internal expected-value register reset to 8'h00.
  - Each dout_valid compares dout to the expected value, increments err_cnt on mismatch, then increments the expected value modulo 256.
  - clear resets err_cnt and the expected value.
- Undefined: no err_cnt port and no checker logic.

Test Plan:
- 256 uart_done strobes with bytes 0x00..0xFF, 20 cycles apart -> rx_count=256, DRAIN entered; 256 dout_valid pulses exactly 4 cycles apart with dout 0x00..0xFF; then frame_done=1, timeout=0, ovf_cnt=0.
- TIMEOUT_CYC=1000: send 10 bytes, then silence -> timeout=1 exactly 1000 cycles after the 10th strobe; 10 outputs; frame_done=1 and rx_count=10.
- Strobe uart_done with 0xAA during DRAIN and twice in DONE -> ovf_cnt=3; 0xAA never appears on dout.
- In DONE, pulse clear together with uart_done -> next state IDLE; rx_count=0, ovf_cnt=0; the byte is not stored.
- Assert sys_rst_n low after 100 bytes in COLLECT -> all outputs 0 immediately, state_dbg=0001; a following 256-byte frame drains correctly.
- RX_PATTERN_CHECK_EN defined: a 256-byte frame with byte 16 replaced by 0x55 -> err_cnt=1 after the drain; with the correct pattern, err_cnt=0.
